neuraedge_pe_drain: RTL and testbench
=====================================

Name: neuraedge_pe_drain

Overview:
Output drain stage directly downstream of a column of neuraedge_pe instances. It captures each PE's 32-bit accumulator result when that PE's accum_valid pulses, then requantises the result to int8 (rounding shift, optional ReLU, saturation). Results leave one per cycle in lane order on a valid/ready stream toward the tile output buffer. It flags a sticky overrun when a PE delivers a new result before the previous frame has drained.

Parameters:
NUM_PE, 4, number of PE lanes drained (≥2)
ACC_W, 32, accumulator width per lane (signed)
OUT_W, 8, requantised output width (signed)
SHIFT_W, 5, width of right-shift config

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
accum_in  input  NUM_PE*ACC_W  packed PE accum_out values, lane i at [i*ACC_W +: ACC_W]
accum_valid_in  input  NUM_PE  per-lane PE accum_valid
cfg_shift  input  SHIFT_W  arithmetic right-shift amount (0..31)
cfg_relu  input  1  clamp negative results to 0
clear_overrun  input  1  synchronous clear of overrun flag
out_data  output  OUT_W  requantised signed result
out_lane  output  $clog2(NUM_PE)  lane index of out_data
out_last  output  1  high with the final lane of a frame
out_valid  output  1  stream valid
out_ready  input  1  stream ready from consumer
busy  output  1  high while in DRAIN
overrun  output  1  sticky: a result was dropped

Behaviour:
- Reset (async, rst_n=0): state=COLLECT, capture mask=0, out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0, overrun=0, latched cfg=0. Capture registers need no reset.
- COLLECT: on each edge, every lane with accum_valid_in[i]=1 loads capture[i] and sets mask[i]. A repeat valid on an already-captured lane overwrites the value (last value wins) with no overrun.
- Transition: at the edge where the mask becomes all-ones (including simultaneous captures), state→DRAIN. The same edge latches cfg_shift/cfg_relu into frame config and loads the output register with lane 0's requantised result. out_valid=1 one cycle after the final capture edge.
- DRAIN: busy=1. out_data/out_lane/out_last hold stable while out_valid=1 and out_ready=0.
- A handshake (out_valid&out_ready at an edge) with lane<NUM_PE-1 loads lane+1. With lane=NUM_PE-1 it drops out_valid, clears the mask and returns to COLLECT. Throughput is 1 result/cycle with ready held high.
- out_last=1 exactly when out_lane=NUM_PE-1 and out_valid=1.
- accum_valid_in[i]=1 in DRAIN, on any edge except the final handshake edge: the value is dropped and overrun is set. On the final handshake edge the capture is accepted into the new frame: mask[i] is set, not cleared.
- overrun clears when clear_overrun=1. If a new overrun occurs on the same edge, set wins.
- Requant per lane, using frame config:
  - Compute in ACC_W+1 bits signed: if shift>0, t = acc + (1<<(shift-1)), else t = acc; then r = t >>> shift.
  - If relu and r<0, r=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Rounding is half toward +inf. The extra bit prevents overflow at acc=2^31-1.
- cfg changes during DRAIN have no effect until the next frame.
- Reset mid-DRAIN: all outputs return to reset values immediately (async) and the partial frame is discarded.

Decomposition:
- Package neuraedge_pkg: ACC_W/OUT_W defaults, and the drain state enum {COLLECT, DRAIN}.
- One natural sub-module: neuraedge_requant, purely combinational (acc, shift, relu → int8). It is reused by other tile output paths and unit-tested separately.
- Lane-select mux and FSM live in neuraedge_pe_drain.

Test Plan:
- NUM_PE=4, shift=4, relu=0, all lanes valid in one cycle with acc={1000,-1000,5000,-5000}, ready=1 → out_valid one cycle later; outputs 63,-62,127,-128 on lanes 0..3 over 4 consecutive cycles; out_last on lane 3; busy falls after it.
- Staggered valids: lane 2 at cycle 0, lanes 0,1 at cycle 3, lane 3 at cycle 5 (acc=100 each, shift=0) → out_valid first at cycle 6; four outputs of 100.
- relu=1, shift=0, acc={-1,0,127,128} → 0,0,127,127. Then shift=31 with acc=2^31-1 → 1, with no overflow.
- Backpressure: ready low for 3 cycles on lane 1 → out_data/out_lane stable for those cycles; no lane skipped; order 0,1,2,3.
- accum_valid_in[1] pulse mid-DRAIN → overrun=1 and output values unchanged. clear_overrun → 0. A valid on the final-handshake edge is captured: mask bit set in COLLECT, no overrun.
- rst_n asserted while out_valid=1 on lane 2 → out_valid=0 and busy=0 immediately. After release, a full new frame drains correctly from lane 0.

Source files
------------

// File: rtl/neuraedge_pkg.sv
// Shared definitions for the neuraedge tile output path.
//   ACC_W_DEF / OUT_W_DEF : default accumulator and requantised widths
//   drain_state_t         : drain stage FSM states
package neuraedge_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } drain_state_t;

endpackage

// File: rtl/neuraedge_requant.sv
// Combinational requantiser: signed accumulator -> signed OUT_W result.
// Rounding right shift (half toward +inf), optional ReLU, saturation.
//   acc    : signed accumulator value
//   shift  : arithmetic right-shift amount
//   relu   : clamp negative results to zero
//   result : saturated signed output
module neuraedge_requant
  import neuraedge_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   result
);

  // One guard bit so adding the rounding constant cannot overflow.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] t;
  logic signed [ACC_W:0] r;

  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    t = {acc[ACC_W-1], acc} + rnd;
    r = t >>> shift;
    if (relu && r[ACC_W]) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (r < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end else begin
      result = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuraedge_pe_drain.sv
// Drain stage behind a column of neuraedge_pe lanes. Captures each lane's
// accumulator on its valid pulse; once every lane has a value the frame is
// requantised and streamed out one lane per cycle in lane order.
//   clk, rst_n            : clock, async active-low reset
//   accum_in/accum_valid_in : packed per-lane accumulators and valid pulses
//   cfg_shift, cfg_relu   : requant config, latched at frame start
//   clear_overrun         : synchronous clear of the overrun flag
//   out_data/out_lane/out_last/out_valid/out_ready : result stream
//   busy                  : frame draining
//   overrun               : sticky, a lane result arrived mid-drain and was dropped
module neuraedge_pe_drain
  import neuraedge_pkg::*;
#(
  parameter  int NUM_PE  = 4,
  parameter  int ACC_W   = ACC_W_DEF,
  parameter  int OUT_W   = OUT_W_DEF,
  parameter  int SHIFT_W = 5,
  localparam int LANE_W  = $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PE*ACC_W-1:0] accum_in,
  input  logic [NUM_PE-1:0]       accum_valid_in,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    clear_overrun,
  output logic [OUT_W-1:0]        out_data,
  output logic [LANE_W-1:0]       out_lane,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_PE - 1);

  drain_state_t       state;
  logic [ACC_W-1:0]   capture [NUM_PE];
  logic [NUM_PE-1:0]  mask;
  logic [NUM_PE-1:0]  mask_next;
  logic [SHIFT_W-1:0] frame_shift;
  logic               frame_relu;
  logic [LANE_W-1:0]  next_lane;
  logic               handshake;
  logic               final_hs;
  logic               drop;

  logic signed [ACC_W-1:0]   rq_acc;
  logic        [SHIFT_W-1:0] rq_shift;
  logic                      rq_relu;
  logic signed [OUT_W-1:0]   rq_out;

  always_comb begin
    mask_next = mask | accum_valid_in;
    handshake = out_valid & out_ready;
    final_hs  = handshake && (out_lane == LAST_LANE);
    next_lane = out_lane + LANE_W'(1);
    drop      = (state == DRAIN) && (|accum_valid_in) && !final_hs;
    // In COLLECT the requantiser prepares lane 0 for the frame-start edge,
    // bypassing the capture register in case lane 0 arrives on that edge,
    // and uses live config since it is latched on that same edge.
    if (state == COLLECT) begin
      rq_acc   = accum_valid_in[0] ? accum_in[ACC_W-1:0] : capture[0];
      rq_shift = cfg_shift;
      rq_relu  = cfg_relu;
    end else begin
      rq_acc   = capture[next_lane];
      rq_shift = frame_shift;
      rq_relu  = frame_relu;
    end
  end

  neuraedge_requant #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc    (rq_acc),
    .shift  (rq_shift),
    .relu   (rq_relu),
    .result (rq_out)
  );

  // Capture is frozen during DRAIN except on the final handshake edge,
  // where arrivals belong to the next frame.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (accum_valid_in[i] && ((state == COLLECT) || final_hs)) begin
        capture[i] <= accum_in[i*ACC_W +: ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      mask        <= '0;
      frame_shift <= '0;
      frame_relu  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_lane    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          mask <= mask_next;
          if (&mask_next) begin
            state       <= DRAIN;
            frame_shift <= cfg_shift;
            frame_relu  <= cfg_relu;
            out_valid   <= 1'b1;
            out_data    <= rq_out;
            out_lane    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (out_lane == LAST_LANE) begin
              state     <= COLLECT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              mask      <= accum_valid_in;
            end else begin
              out_lane <= next_lane;
              out_data <= rq_out;
              out_last <= (next_lane == LAST_LANE);
            end
          end
        end
        default: state <= COLLECT;
      endcase

      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuraedge_pe_drain.sv
// Directed self-checking bench for neuraedge_pe_drain (NUM_PE=4).
module tb_neuraedge_pe_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] accum_in;
  logic [3:0]   accum_valid_in;
  logic [4:0]   cfg_shift;
  logic         cfg_relu;
  logic         clear_overrun;
  logic [7:0]   out_data;
  logic [1:0]   out_lane;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;

  int n_cmp = 0;
  int n_err = 0;

  neuraedge_pe_drain #(
    .NUM_PE  (4),
    .ACC_W   (32),
    .OUT_W   (8),
    .SHIFT_W (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .accum_in       (accum_in),
    .accum_valid_in (accum_valid_in),
    .cfg_shift      (cfg_shift),
    .cfg_relu       (cfg_relu),
    .clear_overrun  (clear_overrun),
    .out_data       (out_data),
    .out_lane       (out_lane),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    accum_in = {a3, a2, a1, a0};
  endtask

  task automatic exp_out(input string tag, input int lane, input int data, input bit last);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".lane"}, out_lane, lane);
    chk({tag, ".data"}, $signed(out_data), data);
    chk({tag, ".last"}, out_last, last);
  endtask

  initial begin
    rst_n          = 1'b0;
    accum_in       = '0;
    accum_valid_in = '0;
    cfg_shift      = '0;
    cfg_relu       = 1'b0;
    clear_overrun  = 1'b0;
    out_ready      = 1'b0;
    step();
    step();
    chk("rst.valid", out_valid, 0);
    chk("rst.data", out_data, 0);
    chk("rst.lane", out_lane, 0);
    chk("rst.last", out_last, 0);
    chk("rst.busy", busy, 0);
    chk("rst.overrun", overrun, 0);
    rst_n = 1'b1;
    step();

    // Basic frame: rounding and saturation both directions.
    set_acc(1000, -1000, 5000, -5000);
    cfg_shift = 5'd4;
    out_ready = 1'b1;
    accum_valid_in = 4'hF;
    step();
    accum_valid_in = 4'h0;
    exp_out("t1.l0", 0, 63, 0);
    chk("t1.busy", busy, 1);
    cfg_shift = 5'd0;  // must not affect the frame in flight
    step(); exp_out("t1.l1", 1, -62, 0);
    step(); exp_out("t1.l2", 2, 127, 0);
    step(); exp_out("t1.l3", 3, -128, 1);
    step();
    chk("t1.end.valid", out_valid, 0);
    chk("t1.end.busy", busy, 0);
    chk("t1.end.last", out_last, 0);

    // Staggered arrivals.
    set_acc(100, 100, 100, 100);
    cfg_shift = 5'd0;
    accum_valid_in = 4'b0100; step();
    accum_valid_in = 4'b0000; step();
    step();
    accum_valid_in = 4'b0011; step();
    accum_valid_in = 4'b0000; step();
    chk("t2.wait.valid", out_valid, 0);
    accum_valid_in = 4'b1000; step();
    accum_valid_in = 4'b0000;
    exp_out("t2.l0", 0, 100, 0);
    step(); exp_out("t2.l1", 1, 100, 0);
    step(); exp_out("t2.l2", 2, 100, 0);
    step(); exp_out("t2.l3", 3, 100, 1);
    step();
    chk("t2.end.valid", out_valid, 0);

    // ReLU with clip at top.
    set_acc(-1, 0, 127, 128);
    cfg_relu = 1'b1;
    accum_valid_in = 4'hF; step();
    accum_valid_in = 4'h0;
    cfg_relu = 1'b0;
    exp_out("t3.l0", 0, 0, 0);
    step(); exp_out("t3.l1", 1, 0, 0);
    step(); exp_out("t3.l2", 2, 127, 0);
    step(); exp_out("t3.l3", 3, 127, 1);
    step();

    // Extreme shift on extreme accumulators.
    set_acc(32'h7FFF_FFFF, 32'h8000_0000, 0, 1);
    cfg_shift = 5'd31;
    accum_valid_in = 4'hF; step();
    accum_valid_in = 4'h0;
    exp_out("t4.l0", 0, 1, 0);
    step(); exp_out("t4.l1", 1, -1, 0);
    step(); exp_out("t4.l2", 2, 0, 0);
    step(); exp_out("t4.l3", 3, 0, 1);
    step();

    // Backpressure on lane 1.
    set_acc(10, 20, 30, 40);
    cfg_shift = 5'd0;
    accum_valid_in = 4'hF; step();
    accum_valid_in = 4'h0;
    exp_out("t5.l0", 0, 10, 0);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_out("t5.hold", 1, 20, 0);
      step();
    end
    exp_out("t5.hold", 1, 20, 0);
    out_ready = 1'b1;
    step(); exp_out("t5.l2", 2, 30, 0);
    step(); exp_out("t5.l3", 3, 40, 1);
    step();
    chk("t5.end.valid", out_valid, 0);

    // Overrun: a mid-drain arrival is dropped.
    set_acc(5, 6, 7, 8);
    out_ready = 1'b0;
    accum_valid_in = 4'hF; step();
    accum_valid_in = 4'h0;
    exp_out("t6.l0", 0, 5, 0);
    set_acc(5, 99, 7, 8);
    accum_valid_in = 4'b0010; step();
    accum_valid_in = 4'b0000;
    chk("t6.overrun", overrun, 1);
    exp_out("t6.l0held", 0, 5, 0);
    clear_overrun = 1'b1;
    out_ready = 1'b1;
    step();
    clear_overrun = 1'b0;
    chk("t6.cleared", overrun, 0);
    exp_out("t6.l1", 1, 6, 0);
    step(); exp_out("t6.l2", 2, 7, 0);
    step(); exp_out("t6.l3", 3, 8, 1);
    // Arrival on the final handshake edge starts the next frame.
    set_acc(50, 0, 0, 0);
    accum_valid_in = 4'b0001; step();
    accum_valid_in = 4'b0000;
    chk("t6.fh.valid", out_valid, 0);
    chk("t6.fh.overrun", overrun, 0);
    chk("t6.fh.busy", busy, 0);
    set_acc(0, 51, 52, 53);
    accum_valid_in = 4'b1110; step();
    accum_valid_in = 4'b0000;
    exp_out("t6.n0", 0, 50, 0);
    // Set beats clear on the same edge.
    accum_valid_in = 4'b0100;
    clear_overrun = 1'b1;
    step();
    accum_valid_in = 4'b0000;
    chk("t6.setwins", overrun, 1);
    exp_out("t6.n1", 1, 51, 0);
    step();
    clear_overrun = 1'b0;
    chk("t6.clear2", overrun, 0);
    exp_out("t6.n2", 2, 52, 0);
    step(); exp_out("t6.n3", 3, 53, 1);
    step();

    // Reset mid-drain.
    set_acc(1, 2, 3, 4);
    accum_valid_in = 4'hF; step();
    accum_valid_in = 4'h0;
    step();
    step();
    exp_out("t7.l2", 2, 3, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t7.rst.valid", out_valid, 0);
    chk("t7.rst.busy", busy, 0);
    chk("t7.rst.lane", out_lane, 0);
    step();
    rst_n = 1'b1;
    set_acc(-16, 16, 24, -24);
    cfg_shift = 5'd3;
    accum_valid_in = 4'b1110; step();
    accum_valid_in = 4'b0000;
    chk("t7.partial.valid", out_valid, 0);
    accum_valid_in = 4'b0001; step();
    accum_valid_in = 4'b0000;
    exp_out("t7.n0", 0, -2, 0);
    step(); exp_out("t7.n1", 1, 2, 0);
    step(); exp_out("t7.n2", 2, 3, 0);
    step(); exp_out("t7.n3", 3, -3, 1);
    step();
    chk("t7.end.valid", out_valid, 0);
    chk("t7.end.busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
